// File: rtl/tff_count_ctrl_if.sv
// Control/status bundle for the T flip-flop count sequencer.
interface tff_count_ctrl_if #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
);
  logic              start;
  logic              up;
  logic [WIDTH-1:0]  mod_n;
  logic [STEP_W-1:0] steps;
  logic              pause;
  logic              stop;
  logic [WIDTH-1:0]  t_out;
  logic [WIDTH-1:0]  q;
  logic              busy;
  logic              done;
  logic              tc;

  // Requester side: issues commands, observes the bank.
  modport master (
    output start, up, mod_n, steps, pause, stop,
    input  t_out, q, busy, done, tc
  );

  // Sequencer side.
  modport slave (
    input  start, up, mod_n, steps, pause, stop,
    output t_out, q, busy, done, tc
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// Sequencer driving a bank of T flip-flops to count up/down modulo N for a
// programmed number of steps, with pause, abort and a completion pulse.
module tff_count_ctrl #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  tff_count_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Run parameters captured on an accepted start.
  typedef struct packed {
    logic              up;
    logic [WIDTH-1:0]  mod_n;
    logic [STEP_W-1:0] steps;
  } cfg_t;

  logic [1:0]        state;
  logic [1:0]        state_next;
  cfg_t              cfg;
  logic [STEP_W-1:0] cnt;
  logic [STEP_W-1:0] cnt_next;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  t_vec;
  logic              tc_c;
  logic              busy_r;
  logic              done_r;
  logic [WIDTH-1:0]  m_last;
  logic [WIDTH-1:0]  init_val;
  logic [WIDTH-1:0]  q_step;
  logic              wrap;

  // M-1 in WIDTH-bit arithmetic; mod_n = 0 naturally yields 2^WIDTH - 1.
  assign m_last   = cfg.mod_n - WIDTH'(1);
  assign init_val = cfg.up ? '0 : m_last;

  // Next count value modulo M and the wrap condition that raises tc.
  always_comb begin
    q_step = q;
    wrap   = 1'b0;
    if (cfg.up) begin
      if (q == m_last) begin
        q_step = '0;
        wrap   = 1'b1;
      end else begin
        q_step = q + WIDTH'(1);
      end
    end else begin
      if (q == '0) begin
        q_step = m_last;
        wrap   = 1'b1;
      end else begin
        q_step = q - WIDTH'(1);
      end
    end
  end

  // Next-state, step counter and toggle vector; reset forces a quiet bank.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    t_vec      = '0;
    tc_c       = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state_next = S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.stop) begin
            state_next = S_IDLE;
          end else begin
            t_vec      = q ^ init_val;
            cnt_next   = cfg.steps;
            state_next = (cfg.steps != '0) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            state_next = S_IDLE;
          end else if (!bus.pause) begin
            t_vec    = q ^ q_step;
            tc_c     = wrap;
            cnt_next = cnt - STEP_W'(1);
            if (cnt == STEP_W'(1)) begin
              state_next = S_DONE;
            end
          end
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Capture run parameters when a start is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg <= '0;
    end else if (state == S_IDLE && bus.start) begin
      cfg <= '{up: bus.up, mod_n: bus.mod_n, steps: bus.steps};
    end
  end

  // Remaining step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  // T-stage bank: the toggle vector is its only write path.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= q ^ t_vec;
    end
  end

  // Registered status flags decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next == S_LOAD) || (state_next == S_RUN);
      done_r <= (state_next == S_DONE);
    end
  end

  assign bus.t_out = t_vec;
  assign bus.tc    = tc_c;
  assign bus.q     = q;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Self-checking bench for tff_count_ctrl: directed scenarios plus random
// traffic, all compared cycle by cycle against an arithmetic reference model.
module tb_tff_count_ctrl;

  localparam int W  = 4;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tff_count_ctrl_if #(.WIDTH(W), .STEP_W(SW)) bus ();

  tff_count_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 load, 2 run, 3 done; q and modulus as plain ints.
  int m_ph, m_q, m_cnt, m_up, m_mod, m_steps;
  int n_ph, n_q, n_cnt, n_up, n_mod, n_steps;
  int exp_t, exp_tc;
  int obs_done, obs_tc;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_q = 0; m_cnt = 0; m_up = 0; m_mod = 1 << W; m_steps = 0;
  endtask

  // Expected combinational outputs and next model state for the current inputs.
  task automatic model_eval();
    int tgt;
    exp_t = 0; exp_tc = 0;
    n_ph = m_ph; n_q = m_q; n_cnt = m_cnt; n_up = m_up; n_mod = m_mod; n_steps = m_steps;
    if (rst) begin
      n_ph = 0; n_q = 0; n_cnt = 0; n_up = 0; n_mod = 1 << W; n_steps = 0;
    end else begin
      case (m_ph)
        0: if (bus.start) begin
          n_up    = int'(bus.up);
          n_mod   = (bus.mod_n == 0) ? (1 << W) : int'(bus.mod_n);
          n_steps = int'(bus.steps);
          n_ph    = 1;
        end
        1: if (bus.stop) n_ph = 0;
           else begin
             tgt   = m_up ? 0 : m_mod - 1;
             exp_t = m_q ^ tgt;
             n_cnt = m_steps;
             n_ph  = (m_steps == 0) ? 3 : 2;
           end
        2: if (bus.stop) n_ph = 0;
           else if (!bus.pause) begin
             tgt    = m_up ? (m_q + 1) % m_mod : (m_q + m_mod - 1) % m_mod;
             exp_tc = m_up ? int'(m_q == m_mod - 1) : int'(m_q == 0);
             exp_t  = m_q ^ tgt;
             n_cnt  = m_cnt - 1;
             if (n_cnt == 0) n_ph = 3;
           end
        default: n_ph = 0;
      endcase
      n_q = m_q ^ exp_t;
    end
  endtask

  // One clock: inputs already applied at the falling edge.
  task automatic tick();
    model_eval();
    #1;
    chk("t_out", int'(bus.t_out), exp_t);
    chk("tc",    int'(bus.tc),    exp_tc);
    chk("q",     int'(bus.q),     m_q);
    chk("busy",  int'(bus.busy),  int'(m_ph == 1 || m_ph == 2));
    chk("done",  int'(bus.done),  int'(m_ph == 3));
    obs_done = int'(bus.done);
    obs_tc   = int'(bus.tc);
    @(posedge clk);
    m_ph = n_ph; m_q = n_q; m_cnt = n_cnt; m_up = n_up; m_mod = n_mod; m_steps = n_steps;
    @(negedge clk);
  endtask

  task automatic quiet();
    rst = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
  endtask

  // Directed run: start at call 0, optional pause window, stop and stray start.
  task automatic run_dir(input string name, input int up, input int mod, input int steps,
                         input int p_from, input int p_len, input int stop_at,
                         input int glitch_at, input int exp_done, input int exp_q,
                         input int exp_tcs);
    int done_at;
    int tcs;
    done_at = -1;
    tcs = 0;
    for (int c = 0; c < 300; c++) begin
      rst       = 1'b0;
      bus.start = (c == 0) || (c == glitch_at);
      bus.up    = (c == 0) ? up[0] : 1'($urandom);
      bus.mod_n = (c == 0) ? W'(mod) : W'($urandom);
      bus.steps = (c == 0) ? SW'(steps) : SW'($urandom);
      bus.pause = (c >= p_from) && (c < p_from + p_len);
      bus.stop  = (c == stop_at);
      tick();
      tcs += obs_tc;
      if (obs_done != 0) begin
        done_at = c;
        break;
      end
      if (stop_at >= 0 && c > stop_at) break;
    end
    quiet();
    #1;
    chk({name, "_done_cycle"}, done_at, exp_done);
    chk({name, "_final_q"}, int'(bus.q), exp_q);
    chk({name, "_tc_count"}, tcs, exp_tcs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    quiet();
    rst = 1'b1;
    bus.up = 1'b0; bus.mod_n = '0; bus.steps = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    #1;
    chk("reset_q", int'(bus.q), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_t_out", int'(bus.t_out), 0);

    // Reset mid-run once q reaches 5.
    bus.up = 1'b1; bus.mod_n = W'(10); bus.steps = SW'(20);
    for (int c = 0; c < 7; c++) begin
      bus.start = (c == 0);
      tick();
    end
    #1;
    chk("midrun_q", int'(bus.q), 5);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("postrst_q", int'(bus.q), 0);
    chk("postrst_busy", int'(bus.busy), 0);
    chk("postrst_done", int'(bus.done), 0);
    chk("postrst_t_out", int'(bus.t_out), 0);
    tick();

    run_dir("up10",  1, 10, 12, -1, 0, -1, -1, 14, 2, 1);
    run_dir("dn3",   0,  0,  3, -1, 0, -1, -1,  5, 12, 0);
    run_dir("dn16",  0,  0, 16, -1, 0, -1, -1, 18, 15, 1);
    run_dir("pause", 1,  4,  4,  4, 3, -1,  3,  9, 0, 1);
    run_dir("stop",  1,  8, 10, -1, 0,  4, -1, -1, 2, 0);
    run_dir("zero",  0,  6,  0, -1, 0, -1, -1,  2, 5, 0);
    run_dir("mod1",  1,  1,  5, -1, 0, -1, -1,  7, 0, 5);

    // Random traffic checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.up    = 1'($urandom);
      bus.mod_n = W'($urandom);
      bus.steps = ($urandom_range(0, 49) == 0) ? SW'($urandom) : SW'($urandom_range(0, 12));
      bus.pause = ($urandom_range(0, 4) == 0);
      bus.stop  = ($urandom_range(0, 39) == 0);
      tick();
    end
    quiet();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencer for a WIDTH-bit bank of toggle (T) flip-flops. It drives each stage's T input so that the bank counts up or down modulo a programmable N for a programmed number of steps. It also supports pause, abort and a completion pulse. The T-stage bank (q <= q ^ t_out) is instantiated inside the block, so the toggle vector and the bank state are both observable at the ports. The block serves as the counting/sequencing engine that lab-level designs use instead of hand-wiring T flip-flops.

## Interface
- WIDTH, 4: number of T stages in the bank.
- STEP_W, 8: width of the step-count input and the internal step counter.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset; sampled on rising clk.
- start  in  1  request to run; sampled only in IDLE.
- up  in  1  direction, captured at start: 1 = count up, 0 = count down.
- mod_n  in  WIDTH  modulus, captured at start; 0 means 2^WIDTH.
- steps  in  STEP_W  number of count steps, captured at start.
- pause  in  1  while high in RUN, toggling stops and the step counter holds.
- stop  in  1  abort; leaves LOAD or RUN immediately.
- t_out  out  WIDTH  toggle vector applied to the bank this cycle (combinational).
- q  out  WIDTH  T-bank state (registered).
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse in DONE.
- tc  out  1  terminal-count pulse, high in the cycle whose step wraps the bank (combinational).

## Operation
- Reset:
  - state = IDLE; q = 0; step counter = 0; captured up/mod_n/steps = 0.
  - t_out = 0, busy = 0, done = 0, tc = 0.
  - rst overrides every other input, including mid-run.
- Bank update: each edge, q <= q ^ t_out. The bank is never written by any other path.
- Let M = mod_n (or 2^WIDTH when mod_n = 0). Let init = 0 when up = 1, and M-1 when up = 0.
- States:
  - IDLE:
    - t_out = 0.
    - start = 1: capture up/mod_n/steps and go to LOAD.
    - start is ignored in all other states.
  - LOAD (one cycle):
    - t_out = q ^ init, so q = init after the edge.
    - Next state is RUN if steps ≠ 0, otherwise DONE.
    - Step counter is loaded with steps.
  - RUN:
    - When pause = 0: t_out = q ^ next(q), where next(q) is (q+1) mod M when counting up and (q-1) mod M when counting down. The step counter decrements.
    - Wrap cases set tc = 1: up with q = M-1 (next = 0), and down with q = 0 (next = M-1).
    - After the edge where the counter reaches 0, go to DONE.
    - When pause = 1: t_out = 0, tc = 0, the counter holds and the state holds.
  - DONE:
    - done = 1 for exactly one cycle; t_out = 0.
    - Always returns to IDLE. A start in this cycle is ignored.
- stop = 1 in LOAD or RUN:
  - t_out = 0 that cycle; next state is IDLE.
  - q keeps its current value; no done pulse.
  - stop has priority over pause and over completion.
- Width rules:
  - All modulo arithmetic is WIDTH bits.
  - mod_n = 1 keeps q at 0, and every RUN step asserts tc.
  - Inputs other than start, stop and pause are don't-care outside the start cycle.

## Timing
- start sampled high at edge E0:
  - LOAD during cycle E0..E1; q = init after E1.
  - Steps applied at edges E2..E(steps+1).
  - done is high during cycle E(steps+1)..E(steps+2).
  - busy is high from E0 to E(steps+1).
- Latency with no pauses: steps + 2 cycles from the start edge to the done cycle. Each paused RUN cycle adds 1.
- With steps = 0, done follows LOAD directly (2 cycles).
- Back-to-back runs: the earliest accepted start is in the IDLE cycle after DONE. Minimum spacing is steps + 3 cycles.
- tc coincides with the wrapping t_out; the wrapped q is visible after the following edge.

## Test plan
- Reset: assert rst for 2 cycles mid-run (state RUN, q = 5) -> next cycle q = 0, busy = 0, done = 0, t_out = 0; state is IDLE.
- Up count: mod_n = 10, steps = 12, up = 1, no pause.
  - q sequence after LOAD is 0,1,…,9,0,1,2.
  - tc is high once, in the 9->0 step.
  - done is high in cycle 14 after the start edge; final q = 2.
- Down count at full modulus: mod_n = 0, steps = 3, up = 0.
  - q goes 15,14,13,12; tc never asserted; done at cycle 5.
  - Repeat with steps = 16: q returns to 15 and tc pulses once on the 0->15 step.
- Pause and ignored start: up, mod_n = 4, steps = 4; pause high for 3 cycles after the second step.
  - q holds at 2 and t_out = 0 for those cycles.
  - done arrives 3 cycles later than the unpaused case.
  - A start pulse during RUN changes nothing.
- Stop and zero steps: stop asserted in the 3rd RUN cycle of an up/mod 8/steps 10 run.
  - State goes to IDLE and q holds at 2; no done.
  - Then steps = 0: q = init and done appear 2 cycles after start.
